// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches one-cycle press pulses into HOLD/GAP bursts with a saturating replay queue (option: STRETCH_RETRIGGER_EN)
module pulse_stretch #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 16,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_pulse,
  output logic              out_level,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d, out_q, busy_q;
  logic              tz, retrig, inc, dec;
  assign tz = timer_q == '0;
`ifdef STRETCH_RETRIGGER_EN
  assign retrig = in_pulse && state_q == HOLD;
`else
  assign retrig = 1'b0;
`endif
  assign inc = in_pulse && state_q != IDLE && !retrig;
  assign dec = state_q == GAP && tz && (pend_q != '0 || in_pulse);
  // next state, timer reload/countdown and queue bookkeeping
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_pulse) begin
        state_d = HOLD;
        timer_d = HOLD_LD;
      end
      HOLD: if (retrig) timer_d = HOLD_LD;
      else if (tz) begin
        state_d = GAP;
        timer_d = GAP_LD;
      end else timer_d = timer_q - 1'b1;
      GAP: if (tz) begin
        state_d = dec ? HOLD : IDLE;
        timer_d = dec ? HOLD_LD : '0;
      end else timer_d = timer_q - 1'b1;
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    if (inc && !dec) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else pend_d = pend_q + 1'b1;
    end else if (dec && !inc) pend_d = pend_q - 1'b1;
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      out_q   <= state_d == HOLD;
      busy_q  <= state_d != IDLE;
    end
  end
  assign out_level = out_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed checks of burst timing, replay queue, saturation and async clear
module tb_pulse_stretch;
  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       in_pulse = 1'b0;
  logic       out_level, busy, overflow;
  logic [1:0] pending;
  int         n_chk = 0;
  int         n_fail = 0;
  pulse_stretch dut (
    .clk(clk), .clear(clear), .in_pulse(in_pulse),
    .out_level(out_level), .busy(busy), .pending(pending), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int idx, input logic l, input logic b,
                     input logic [1:0] p, input logic o);
    n_chk++;
    assert ({out_level, busy, pending, overflow} === {l, b, p, o})
    else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed lvl=%b busy=%b pend=%0d ovf=%b expected lvl=%b busy=%b pend=%0d ovf=%b",
             tag, idx, out_level, busy, pending, overflow, l, b, p, o);
    end
  endtask
  task automatic restart();
    clear = 1'b1;
    in_pulse = 1'b0;
    tick();
    clear = 1'b0;
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("reset", 0, 1'b0, 1'b0, 2'd0, 1'b0);
    clear = 1'b0;
    tick();
    chk("post_reset", 0, 1'b0, 1'b0, 2'd0, 1'b0);
    in_pulse = 1'b1;
    tick();
    in_pulse = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("single", i, i < 8, i < 12, 2'd0, 1'b0);
      tick();
    end
    restart();
    in_pulse = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      chk("three", i, (i % 12) < 8 && i < 36, i < 36,
          i == 0 ? 2'd0 : i == 1 ? 2'd1 : i < 12 ? 2'd2 : i < 24 ? 2'd1 : 2'd0, 1'b0);
      in_pulse = i < 2;
      tick();
    end
    restart();
    in_pulse = 1'b1;
    tick();
    for (int i = 0; i < 52; i++) begin
      chk("sat", i, (i % 12) < 8 && i < 48, i < 48,
          i < 3 ? 2'(i) : i < 12 ? 2'd3 : i < 24 ? 2'd2 : i < 36 ? 2'd1 : 2'd0, i >= 4);
      in_pulse = i < 5;
      tick();
    end
    restart();
    in_pulse = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_pulse = i < 2;
      tick();
    end
    chk("pre_clear", 4, 1'b1, 1'b1, 2'd2, 1'b0);
    #2;
    clear = 1'b1;
    #1;
    chk("async_clear", 0, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("after_clear", i, 1'b0, 1'b0, 2'd0, 1'b0);
    end
    restart();
    in_pulse = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      chk("gap_end", i, (i % 12) < 8 && i < 36, i < 36,
          i == 0 ? 2'd0 : i < 24 ? 2'd1 : 2'd0, 1'b0);
      in_pulse = i == 0 || i == 11;
      tick();
    end
    restart();
    in_pulse = 1'b1;
    tick();
    for (int i = 0; i < 28; i++) begin
`ifdef STRETCH_RETRIGGER_EN
      chk("retrig", i, i < 13, i < 17, 2'd0, 1'b0);
`else
      chk("retrig", i, (i % 12) < 8 && i < 24, i < 24, (i >= 5 && i < 12) ? 2'd1 : 2'd0, 1'b0);
`endif
      in_pulse = i == 4;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
